lcd12864_serial_rx: RTL and testbench

- Receiver for the ST7920/LCD12864 3-wire serial interface (CS, SCLK, SID), i.e. the LCD-side end of the link our serial LCD driver transmits on.
- Oversamples the asynchronous serial lines with the system clock, validates 24-bit frames and emits the decoded byte with its RS/RW flags as a one-cycle strobe.
- Used as an on-FPGA loopback checker for the LCD driver and as the display model in system benches.

---
 rtl/lcd12864_serial_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_lcd12864_serial_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd12864_serial_rx.sv
// ---------------------------------------------------------------------------
// lcd12864_serial_rx
//
// LCD-side receiver for the ST7920 / LCD12864 3-wire serial link.
// The asynchronous CS/SCLK/SID lines are oversampled with clk. SID is taken
// on each rising SCLK edge seen while CS is high. 24-bit frames are checked:
//   1 1 1 1 1 RW RS 0 | D7..D4 0000 | D3..D0 0000
// A good frame ends with a one-cycle valid pulse. At that pulse data/rs/rw
// take the new values, and they hold those values afterwards.
//
// Ports
//   clk        system clock (>= 4x SCLK)
//   CR         synchronous active-high reset
//   CS         chip select, active high (asynchronous)
//   SCLK       serial clock (asynchronous)
//   SID        serial data, MSB first (asynchronous)
//   data[7:0]  decoded byte of the last good frame
//   rs, rw     RS / RW flags of the last good frame
//   valid      one-cycle pulse per good frame
//   frame_err  one-cycle pulse per discarded frame
//   busy       high while a frame is partially received
//
// Parameters
//   SYNC_STAGES  synchroniser depth on CS/SCLK/SID (use 2 or more)
//   CHECK_PAD    non-zero: pad / header-zero bits that are set cause a discard
// ---------------------------------------------------------------------------
module lcd12864_serial_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_PAD   = 1
) (
    input  logic       clk,
    input  logic       CR,
    input  logic       CS,
    input  logic       SCLK,
    input  logic       SID,
    output logic [7:0] data,
    output logic       rs,
    output logic       rw,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam bit LP_CHECK = (CHECK_PAD != 0);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_HDR,
        ST_HI,
        ST_LO,
        ST_SKIP
    } state_t;

    // Synchroniser chain. Each stage holds the bits {CS, SCLK, SID}.
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  w_pins;
    logic                        w_cs_s;
    logic                        w_sclk_s;
    logic                        w_sid_s;

    assign w_pins   = {CS, SCLK, SID};
    assign w_cs_s   = r_sync[SYNC_STAGES-1][2];
    assign w_sclk_s = r_sync[SYNC_STAGES-1][1];
    assign w_sid_s  = r_sync[SYNC_STAGES-1][0];

    always_ff @(posedge clk) begin
        if (CR) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    logic       r_sclk_prev;
    logic       r_cs_prev;
    state_t     r_state;
    logic [4:0] r_bit_cnt;
    logic       r_rw_sh;
    logic       r_rs_sh;
    logic [7:0] r_byte_sh;
    logic [7:0] r_data;
    logic       r_rs;
    logic       r_rw;
    logic       r_valid;
    logic       r_err;
    logic       r_busy;

    logic w_edge;
    logic w_cs_fall;
    logic w_pad_bad;

    // CS gating: an SCLK edge that coincides with a low synced CS is ignored.
    assign w_edge    = w_sclk_s & ~r_sclk_prev & w_cs_s;
    assign w_cs_fall = ~w_cs_s & r_cs_prev;
    assign w_pad_bad = LP_CHECK & w_sid_s;

    // The bit counter gives the position within the frame: 0-4 SYNC, 5-7 HDR,
    // 8-15 HI, 16-23 LO. In SYNC it also counts the leading 1s.
    // ST_SKIP is entered when a frame is discarded part-way through. The
    // remaining bit slots are counted and ignored, so the receiver stays
    // aligned for a following frame under the same CS. Exactly one
    // frame_err is raised for the discarded frame.
    always_ff @(posedge clk) begin
        if (CR) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_state     <= ST_SYNC;
            r_bit_cnt   <= 5'd0;
            r_rw_sh     <= 1'b0;
            r_rs_sh     <= 1'b0;
            r_byte_sh   <= 8'h00;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_rw        <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;

            if (w_cs_fall) begin
                // Frame cut short by CS. A frame that was already discarded
                // has reported its error, so it does not report another.
                if (r_bit_cnt != 5'd0) begin
                    r_err     <= (r_state != ST_SKIP);
                    r_state   <= ST_SYNC;
                    r_bit_cnt <= 5'd0;
                    r_busy    <= 1'b0;
                end
            end else if (w_edge) begin
                case (r_state)
                    ST_SYNC: begin
                        if (w_sid_s) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_busy    <= 1'b1;
                            if (r_bit_cnt == 5'd4) begin
                                r_state <= ST_HDR;
                            end
                        end else begin
                            // Idle zeros with no 1s counted are not a frame.
                            r_err     <= LP_CHECK && (r_bit_cnt != 5'd0);
                            r_bit_cnt <= 5'd0;
                            r_busy    <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        if (r_bit_cnt == 5'd5) begin
                            r_rw_sh <= w_sid_s;
                        end
                        if (r_bit_cnt == 5'd6) begin
                            r_rs_sh <= w_sid_s;
                        end
                        if (r_bit_cnt == 5'd7 && w_pad_bad) begin
                            r_err     <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= ST_SKIP;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_state <= ST_HI;
                            end
                        end
                    end
                    ST_HI: begin
                        if (r_bit_cnt < 5'd12) begin
                            r_byte_sh <= {r_byte_sh[6:0], w_sid_s};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end else if (w_pad_bad) begin
                            r_err     <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= ST_SKIP;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd15) begin
                                r_state <= ST_LO;
                            end
                        end
                    end
                    ST_LO: begin
                        if (r_bit_cnt < 5'd20) begin
                            r_byte_sh <= {r_byte_sh[6:0], w_sid_s};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end else if (w_pad_bad) begin
                            r_err  <= 1'b1;
                            r_busy <= 1'b0;
                            if (r_bit_cnt == 5'd23) begin
                                r_state   <= ST_SYNC;
                                r_bit_cnt <= 5'd0;
                            end else begin
                                r_state   <= ST_SKIP;
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end else if (r_bit_cnt == 5'd23) begin
                            r_valid   <= 1'b1;
                            r_data    <= r_byte_sh;
                            r_rs      <= r_rs_sh;
                            r_rw      <= r_rw_sh;
                            r_state   <= ST_SYNC;
                            r_bit_cnt <= 5'd0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    ST_SKIP: begin
                        if (r_bit_cnt == 5'd23) begin
                            r_state   <= ST_SYNC;
                            r_bit_cnt <= 5'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    default: begin
                        r_state   <= ST_SYNC;
                        r_bit_cnt <= 5'd0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data      = r_data;
    assign rs        = r_rs;
    assign rw        = r_rw;
    assign valid     = r_valid;
    assign frame_err = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_lcd12864_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_lcd12864_serial_rx
//
// Drives CS/SCLK/SID at clk/8 into two receivers that share the same inputs:
// one with pad checking and one without. Frames come from a vector table.
// Hand-written sequences cover CS abort, reset in mid-frame and sync faults.
// ---------------------------------------------------------------------------
module tb_lcd12864_serial_rx;

    logic       clk = 1'b0;
    logic       CR;
    logic       CS;
    logic       SCLK;
    logic       SID;

    logic [7:0] data_p, data_n;
    logic       rs_p, rs_n, rw_p, rw_n;
    logic       valid_p, valid_n, frame_err_p, frame_err_n, busy_p, busy_n;

    always #5 clk = ~clk;

    lcd12864_serial_rx #(.SYNC_STAGES(2), .CHECK_PAD(1)) dut_p (
        .clk(clk), .CR(CR), .CS(CS), .SCLK(SCLK), .SID(SID),
        .data(data_p), .rs(rs_p), .rw(rw_p),
        .valid(valid_p), .frame_err(frame_err_p), .busy(busy_p)
    );

    lcd12864_serial_rx #(.SYNC_STAGES(2), .CHECK_PAD(0)) dut_n (
        .clk(clk), .CR(CR), .CS(CS), .SCLK(SCLK), .SID(SID),
        .data(data_n), .rs(rs_n), .rw(rw_n),
        .valid(valid_n), .frame_err(frame_err_n), .busy(busy_n)
    );

    int tests = 0;
    int fails = 0;

    // Pulse counters for both receivers.
    int nv_p = 0, ne_p = 0, nv_n = 0, ne_n = 0, n_both = 0;

    always @(negedge clk) begin
        if (valid_p) nv_p++;
        if (frame_err_p) ne_p++;
        if (valid_n) nv_n++;
        if (frame_err_n) ne_n++;
        if ((valid_p && frame_err_p) || (valid_n && frame_err_n)) n_both++;
    end

    // Expected held outputs of each receiver.
    logic [7:0] exp_d_p = 8'h00, exp_d_n = 8'h00;
    logic       exp_rs_p = 1'b0, exp_rs_n = 1'b0, exp_rw_p = 1'b0, exp_rw_n = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        logic       rw;
        int         flip;   // bit slot (0 = first sent) forced to 1, -1 none
        bit         hold;   // keep CS high into the next vector
        int         ev_p;
        int         ee_p;
        int         ev_n;
        int         ee_n;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        SID  = b;
        SCLK = 1'b0;
        wait_clk(4);
        SCLK = 1'b1;
        wait_clk(4);
        SCLK = 1'b0;
    endtask

    function automatic logic [23:0] mk_frame(input logic [7:0] d, input logic r_s, input logic r_w);
        return {5'b11111, r_w, r_s, 1'b0, d[7:4], 4'b0000, d[3:0], 4'b0000};
    endfunction

    task automatic send_frame(input logic [23:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(f[23-i]);
        end
    endtask

    task automatic check_frame(input string tag,
                               input int v0p, input int e0p, input int v0n, input int e0n,
                               input int evp, input int eep, input int evn, input int een);
        chk({tag, " valid_p"}, nv_p - v0p, evp);
        chk({tag, " err_p"},   ne_p - e0p, eep);
        chk({tag, " valid_n"}, nv_n - v0n, evn);
        chk({tag, " err_n"},   ne_n - e0n, een);
        chk({tag, " data_p"},  int'(data_p), int'(exp_d_p));
        chk({tag, " rs_p"},    int'(rs_p),   int'(exp_rs_p));
        chk({tag, " rw_p"},    int'(rw_p),   int'(exp_rw_p));
        chk({tag, " data_n"},  int'(data_n), int'(exp_d_n));
        chk({tag, " rs_n"},    int'(rs_n),   int'(exp_rs_n));
        chk({tag, " rw_n"},    int'(rw_n),   int'(exp_rw_n));
        chk({tag, " busy_p"},  int'(busy_p), 0);
        chk({tag, " busy_n"},  int'(busy_n), 0);
        $display("[TB] %s: valid %0d/%0d err %0d/%0d data %02h/%02h",
                 tag, nv_p - v0p, nv_n - v0n, ne_p - e0p, ne_n - e0n, data_p, data_n);
    endtask

    initial begin
        int          v0p, e0p, v0n, e0n;
        bit          cs_high;
        logic [23:0] f;

        //        d      rs    rw    flip hold  ev_p ee_p ev_n ee_n
        vecs[0] = '{8'h55, 1'b1, 1'b0, -1, 1'b0, 1, 0, 1, 0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 12, 1'b0, 0, 1, 1, 0};
        vecs[2] = '{8'h0C, 1'b1, 1'b0, -1, 1'b0, 1, 0, 1, 0};
        vecs[3] = '{8'h30, 1'b0, 1'b0, -1, 1'b1, 1, 0, 1, 0};
        vecs[4] = '{8'h41, 1'b1, 1'b0, -1, 1'b0, 1, 0, 1, 0};
        vecs[5] = '{8'h9C, 1'b0, 1'b1,  7, 1'b0, 0, 1, 1, 0};
        vecs[6] = '{8'h3C, 1'b0, 1'b1, 23, 1'b0, 0, 1, 1, 0};
        vecs[7] = '{8'h00, 1'b0, 1'b0, -1, 1'b0, 1, 0, 1, 0};

        CR = 1'b1; CS = 1'b0; SCLK = 1'b0; SID = 1'b0;
        wait_clk(3);
        chk("reset data_p",  int'(data_p), 0);
        chk("reset rs_p",    int'(rs_p), 0);
        chk("reset rw_p",    int'(rw_p), 0);
        chk("reset valid_p", int'(valid_p), 0);
        chk("reset err_p",   int'(frame_err_p), 0);
        chk("reset busy_p",  int'(busy_p), 0);
        chk("reset data_n",  int'(data_n), 0);
        $display("[TB] reset: data %02h rs %0d rw %0d busy %0d", data_p, rs_p, rw_p, busy_p);
        CR = 1'b0;
        wait_clk(5);

        // Table-driven frames.
        cs_high = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v0p = nv_p; e0p = ne_p; v0n = nv_n; e0n = ne_n;
            if (!cs_high) begin
                CS = 1'b1;
                wait_clk(4);
            end
            f = mk_frame(vecs[i].d, vecs[i].rs, vecs[i].rw);
            if (vecs[i].flip >= 0) f[23 - vecs[i].flip] = 1'b1;
            send_frame(f, 24);
            if (!vecs[i].hold) begin
                wait_clk(4);
                CS = 1'b0;
            end
            wait_clk(10);
            cs_high = vecs[i].hold;
            if (vecs[i].ev_p > 0) begin
                exp_d_p = vecs[i].d; exp_rs_p = vecs[i].rs; exp_rw_p = vecs[i].rw;
            end
            if (vecs[i].ev_n > 0) begin
                exp_d_n = vecs[i].d; exp_rs_n = vecs[i].rs; exp_rw_n = vecs[i].rw;
            end
            check_frame($sformatf("vec%0d", i), v0p, e0p, v0n, e0n,
                        vecs[i].ev_p, vecs[i].ee_p, vecs[i].ev_n, vecs[i].ee_n);
        end

        // CS dropped after 10 bits.
        v0p = nv_p; e0p = ne_p; v0n = nv_n; e0n = ne_n;
        CS = 1'b1;
        wait_clk(4);
        send_frame(mk_frame(8'h77, 1'b0, 1'b0), 10);
        wait_clk(4);
        chk("midframe busy_p", int'(busy_p), 1);
        chk("midframe busy_n", int'(busy_n), 1);
        CS = 1'b0;
        wait_clk(10);
        check_frame("cs_drop", v0p, e0p, v0n, e0n, 0, 1, 0, 1);

        // SCLK toggle with CS low.
        v0p = nv_p; e0p = ne_p; v0n = nv_n; e0n = ne_n;
        SID  = 1'b1;
        SCLK = 1'b1;
        wait_clk(4);
        SCLK = 1'b0;
        wait_clk(10);
        check_frame("sclk_cs_low", v0p, e0p, v0n, e0n, 0, 0, 0, 0);

        // Reset pulse at bit 15 of a frame.
        v0p = nv_p; e0p = ne_p; v0n = nv_n; e0n = ne_n;
        CS = 1'b1;
        wait_clk(4);
        send_frame(mk_frame(8'h66, 1'b1, 1'b0), 15);
        wait_clk(4);
        CR = 1'b1;
        wait_clk(1);
        CR = 1'b0;
        exp_d_p = 8'h00; exp_rs_p = 1'b0; exp_rw_p = 1'b0;
        exp_d_n = 8'h00; exp_rs_n = 1'b0; exp_rw_n = 1'b0;
        chk("cr data_p", int'(data_p), 0);
        chk("cr rs_p",   int'(rs_p), 0);
        chk("cr busy_p", int'(busy_p), 0);
        chk("cr data_n", int'(data_n), 0);
        chk("cr busy_n", int'(busy_n), 0);
        CS = 1'b0;
        wait_clk(10);
        check_frame("cr_midframe", v0p, e0p, v0n, e0n, 0, 0, 0, 0);

        v0p = nv_p; e0p = ne_p; v0n = nv_n; e0n = ne_n;
        CS = 1'b1;
        wait_clk(4);
        send_frame(mk_frame(8'hFF, 1'b0, 1'b0), 24);
        wait_clk(4);
        CS = 1'b0;
        wait_clk(10);
        exp_d_p = 8'hFF; exp_rs_p = 1'b0; exp_rw_p = 1'b0;
        exp_d_n = 8'hFF; exp_rs_n = 1'b0; exp_rw_n = 1'b0;
        check_frame("after_cr", v0p, e0p, v0n, e0n, 1, 0, 1, 0);

        // Sync fault 1 1 0, then a clean frame under the same CS.
        v0p = nv_p; e0p = ne_p; v0n = nv_n; e0n = ne_n;
        CS = 1'b1;
        wait_clk(4);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_frame(mk_frame(8'h12, 1'b1, 1'b0), 24);
        wait_clk(4);
        CS = 1'b0;
        wait_clk(10);
        exp_d_p = 8'h12; exp_rs_p = 1'b1; exp_rw_p = 1'b0;
        exp_d_n = 8'h12; exp_rs_n = 1'b1; exp_rw_n = 1'b0;
        check_frame("sync_fault", v0p, e0p, v0n, e0n, 1, 1, 1, 0);

        chk("valid_and_err_same_cycle", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
